pipeline_dmem_responder: RTL

- Memory-side responder for the MEM-stage data interface of the pipelined RV32I core.
- Accepts one load/store request at a time and applies per-lane byte-enable writes to a word array.
- Returns the full read word after a programmable number of wait states.
- Drives a stall back to the pipeline until each request is acknowledged.

---
 rtl/pipeline_dmem_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_dmem_responder.sv
// ---------------------------------------------------------------------------
// pipeline_dmem_responder
//
// Memory-side responder for the MEM-stage data port of the pipelined RV32I
// core. It takes one load or store at a time, waits a fixed number of wait
// states, performs the access on an internal word array, and then returns a
// one-cycle acknowledge. Until that acknowledge arrives it holds the pipeline
// in a stall.
//
// Handshake: i_mem_req is the valid. The requester holds it, together with
// every request field, until it sees o_mem_ack. o_mem_ack is the single-cycle
// completion or ready pulse. Fields are latched when the request is accepted
// in IDLE, so later input changes have no effect. A request that is still
// high during the ACK cycle belongs to the transfer that is completing. The
// responder only samples it again once it is back in IDLE.
//
// Optional feature macro: DMEM_ERR_EN
//   defined   : out-of-range addresses and unsupported store lane patterns
//               are reported on o_mem_err. Such stores are dropped, and such
//               loads return 0.
//   undefined : the address wraps onto the array using its low bits, every
//               lane pattern is written as given, and o_mem_err is 0.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_mem_req            request valid
//   i_mem_wr_en          1 = store, 0 = load
//   i_mem_byte_sel[3:0]  store lane enables
//   i_mem_addr           byte address
//   i_mem_wdata          lane-aligned store data
//   o_mem_rdata          load data (full word, held between loads)
//   o_mem_ack            one-cycle completion pulse
//   o_mem_stall          i_mem_req & ~o_mem_ack
//   o_mem_err            access error, valid with o_mem_ack
//
// The FSM state is observable as r_state.
// ---------------------------------------------------------------------------
module pipeline_dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_req,
  input  logic            i_mem_wr_en,
  input  logic [3:0]      i_mem_byte_sel,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [XLEN-1:0] i_mem_wdata,
  output logic [XLEN-1:0] o_mem_rdata,
  output logic            o_mem_ack,
  output logic            o_mem_stall,
  output logic            o_mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_wr_en;
  logic [3:0]        r_sel;
  logic [AW-1:0]     r_idx;
  logic [XLEN-1:0]   r_wdata;
  logic              r_err;

  // The memory array has no reset. Its contents survive i_rst.
  logic [XLEN-1:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0]     w_idx;
  logic              w_err;

  assign w_idx = i_mem_addr[AW+1:2];

  // The byte offset is irrelevant for whole-word access. The upper address
  // bits only matter when error checking is built in.
  logic w_unused_addr;
  assign w_unused_addr = ^{i_mem_addr[XLEN-1:AW+2], i_mem_addr[1:0]};

`ifdef DMEM_ERR_EN
  logic w_addr_oob;
  logic w_sel_ok;

  // Any set bit above the word index means addr >= 4*DEPTH_WORDS.
  assign w_addr_oob = |i_mem_addr[XLEN-1:AW+2];

  always_comb begin
    w_sel_ok = 1'b0;
    case (i_mem_byte_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_sel_ok = 1'b1;
      default:                   w_sel_ok = 1'b0;
    endcase
  end

  assign w_err = w_addr_oob | (i_mem_wr_en & ~w_sel_ok);
`else
  assign w_err = 1'b0;
`endif

  assign o_mem_stall = i_mem_req & ~o_mem_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_wr_en     <= 1'b0;
      r_sel       <= 4'd0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      o_mem_ack   <= 1'b0;
      o_mem_rdata <= '0;
      o_mem_err   <= 1'b0;
    end else begin
      o_mem_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_mem_req) begin
            r_wr_en <= i_mem_wr_en;
            r_sel   <= i_mem_byte_sel;
            r_idx   <= w_idx;
            r_wdata <= i_mem_wdata;
            r_err   <= w_err;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // A store leaves the read port untouched. An errored load reads 0.
          if (!r_wr_en) o_mem_rdata <= r_err ? '0 : r_mem[r_idx];
          o_mem_ack <= 1'b1;
          o_mem_err <= r_err;
          r_state   <= S_ACK;
        end
        S_ACK: begin
          // Leave unconditionally so a held request is not taken twice.
          o_mem_err <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Store commit happens in the ACCESS cycle. A reset in that same cycle
  // cancels it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == S_ACCESS) && r_wr_en && !r_err) begin
      for (int l = 0; l < 4; l++) begin
        if (r_sel[l]) r_mem[r_idx][8*l +: 8] <= r_wdata[8*l +: 8];
      end
    end
  end

endmodule
